// File: rtl/data_ram_wait.sv
// data_ram_wait: data memory for the minimal SOPC, serving CPU MEM-stage
// loads/stores with a programmable number of wait states.
//
// Parameters:
//   ADDR_WIDTH  - word-address bits; depth = 2**ADDR_WIDTH 32-bit words
//   WAIT_CYCLES - wait states per access (0..15); 0 gives a single-cycle ack
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   mem_ce_i     - access request, held until ack
//   mem_we_i     - 1 = store, 0 = load
//   mem_addr_i   - byte address; word index = mem_addr_i[ADDR_WIDTH+1:2]
//   mem_sel_i    - big-endian byte enables (sel[3] = data[31:24])
//   mem_data_i   - store data
//   mem_data_o   - load data, valid in the ack cycle, held until next load
//   mem_ack_o    - one-cycle access-complete pulse
//   stallreq_o   - pipeline stall request (combinational)
//   err_o        - misalignment error pulse
//
// Optional feature macro: DATA_RAM_MISALIGN_CHK_EN (sel/offset legality check).
// When it is undefined, err_o is tied to 0.

module data_ram_wait #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        stallreq_o,
    output logic        err_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [31:0]             wdata_q;

    logic [31:0]             ram [DEPTH];

    // Access operands: live inputs when entering ACK straight from IDLE,
    // latched copies otherwise.
    logic                    from_idle;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic                    acc_we;
    logic [3:0]              acc_sel;
    logic [31:0]             acc_data;
    logic                    acc_err;
    logic                    do_access;

    // Address bits outside the word index are ignored (array wraps).
    logic                    unused_addr;
    assign unused_addr = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and stall request
    always_comb begin
        state_d    = state_q;
        stallreq_o = 1'b0;
        case (state_q)
            IDLE: begin
                stallreq_o = mem_ce_i;
                if (mem_ce_i) begin
                    state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                stallreq_o = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && mem_ce_i) begin
            cnt_q   <= CNT_W'(WAIT_CYCLES);
            idx_q   <= mem_addr_i[ADDR_WIDTH+1:2];
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            wdata_q <= mem_data_i;
        end else if (state_q == WAIT) begin
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

`ifdef DATA_RAM_MISALIGN_CHK_EN
    logic err_q;
    logic misalign;

    // Legal sel/offset pairs: word, aligned halves, matching bytes, or no lanes.
    always_comb begin
        case (mem_sel_i)
            4'b0000: misalign = 1'b0;
            4'b1111: misalign = (mem_addr_i[1:0] != 2'd0);
            4'b1100: misalign = (mem_addr_i[1:0] != 2'd0);
            4'b0011: misalign = (mem_addr_i[1:0] != 2'd2);
            4'b1000: misalign = (mem_addr_i[1:0] != 2'd0);
            4'b0100: misalign = (mem_addr_i[1:0] != 2'd1);
            4'b0010: misalign = (mem_addr_i[1:0] != 2'd2);
            4'b0001: misalign = (mem_addr_i[1:0] != 2'd3);
            default: misalign = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && mem_ce_i) begin
            err_q <= misalign;
        end
    end

    assign acc_err = from_idle ? misalign : err_q;

    // Error pulse coincides with the ack of the offending access
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else begin
            err_o <= do_access && acc_err;
        end
    end
`else
    assign acc_err = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign from_idle = (state_q == IDLE);
    assign acc_idx   = from_idle ? mem_addr_i[ADDR_WIDTH+1:2] : idx_q;
    assign acc_we    = from_idle ? mem_we_i   : we_q;
    assign acc_sel   = from_idle ? mem_sel_i  : sel_q;
    assign acc_data  = from_idle ? mem_data_i : wdata_q;

    // The access is performed on the edge that enters ACK, so a reset
    // sampled on that edge abandons it.
    assign do_access = (state_d == ACK) && !rst;

    // Byte-lane store; array is never reset
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) begin
                    ram[acc_idx][b*8 +: 8] <= acc_data[b*8 +: 8];
                end
            end
        end
    end

    // Ack pulse and held load data
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ack_o  <= 1'b0;
            mem_data_o <= '0;
        end else begin
            mem_ack_o <= do_access;
            if (do_access && !acc_we && !acc_err) begin
                mem_data_o <= ram[acc_idx];
            end
        end
    end

endmodule
